// File: rtl/conv_seq_pkg.sv
// Shared types and constants for the streaming convolution sequencer.
package conv_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    EMIT  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam logic [2:0] ALU_OP_CONV = 3'b111;
  localparam logic [2:0] ALU_OP_NOP  = 3'b000;

  localparam int SAMPLE_W  = 5;
  localparam int TAPS      = 4;
  localparam int CONV_OUTS = 7;

endpackage

// File: rtl/conv_ola_acc.sv
// Overlap-add accumulator: unpacks the ALU's packed 7-sample partial result,
// adds the 3-sample tail carried from the previous block and keeps the new tail.
// Build option CONV_SEQ_CTRL_SAT_EN: when defined the overlap sums saturate at
// 2^OUT_W-1, otherwise they wrap modulo 2^OUT_W.
module conv_ola_acc
  import conv_seq_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 clear,
  input  logic [31:0]          alu_result,
  output logic [4*OUT_W-1:0]   sum_data,
  output logic [4*OUT_W-1:0]   flush_data
);

  logic [SAMPLE_W-1:0] y      [CONV_OUTS];
  logic [SAMPLE_W-1:0] tail_q [3];
  logic [SAMPLE_W-1:0] tail_d [3];

  function automatic logic [OUT_W-1:0] zext(input logic [SAMPLE_W-1:0] v);
    logic [OUT_W-1:0] r;
    r = '0;
    r[SAMPLE_W-1:0] = v;
    return r;
  endfunction

  function automatic logic [OUT_W-1:0] ola_add(input logic [OUT_W-1:0] a,
                                               input logic [OUT_W-1:0] b);
    logic [OUT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef CONV_SEQ_CTRL_SAT_EN
    ola_add = s[OUT_W] ? {OUT_W{1'b1}} : s[OUT_W-1:0];
`else
    ola_add = s[OUT_W-1:0];
`endif
  endfunction

  // Unpack the ALU result; the ALU only carries the low 2 bits of y6.
  always_comb begin
    for (int k = 0; k < CONV_OUTS - 1; k++) begin
      y[k] = alu_result[SAMPLE_W*k +: SAMPLE_W];
    end
    y[CONV_OUTS-1] = {3'b000, alu_result[31:30]};
  end

  // Output samples for this block and the flush block built from the tail.
  always_comb begin
    sum_data   = '0;
    flush_data = '0;
    for (int i = 0; i < 3; i++) begin
      sum_data[i*OUT_W +: OUT_W]   = ola_add(zext(y[i]), zext(tail_q[i]));
      flush_data[i*OUT_W +: OUT_W] = zext(tail_q[i]);
    end
    sum_data[3*OUT_W +: OUT_W] = zext(y[3]);
  end

  // Tail next-state: replaced by y4..y6 on load, zeroed on clear.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      tail_d[i] = tail_q[i];
    end
    if (clear) begin
      for (int i = 0; i < 3; i++) begin
        tail_d[i] = '0;
      end
    end else if (load) begin
      for (int i = 0; i < 3; i++) begin
        tail_d[i] = y[4+i];
      end
    end
  end

  // Tail registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        tail_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        tail_q[i] <= tail_d[i];
      end
    end
  end

endmodule

// File: rtl/conv_seq_ctrl.sv
// Streaming 1-D convolution sequencer around the ALU's packed 4x4 convolution
// op. One 4-sample block is issued to the ALU per pass; partial results are
// overlap-added and a final flush block drains the tail after the last block.
// Build option CONV_SEQ_CTRL_SAT_EN selects saturating overlap sums.
module conv_seq_ctrl
  import conv_seq_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [TAPS*SAMPLE_W-1:0]   cfg_kernel,
  output logic                       cfg_ready,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [TAPS*SAMPLE_W-1:0]   in_data,
  input  logic                       in_last,
  output logic [31:0]                alu_a,
  output logic [31:0]                alu_b,
  output logic [2:0]                 alu_ctrl,
  input  logic [31:0]                alu_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [4*OUT_W-1:0]         out_data,
  output logic                       out_last,
  output logic                       busy
);

  localparam int BLK_W = TAPS * SAMPLE_W;

  state_t             state_q, state_d;
  logic [BLK_W-1:0]   kernel_q, kernel_d;
  logic [BLK_W-1:0]   blk_q, blk_d;
  logic               last_q, last_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [4*OUT_W-1:0] out_data_q, out_data_d;
  logic               acc_load, acc_clear;
  logic [4*OUT_W-1:0] acc_sum, acc_flush;

  conv_ola_acc #(.OUT_W(OUT_W)) u_acc (
    .clk        (clk),
    .rst        (rst),
    .load       (acc_load),
    .clear      (acc_clear),
    .alu_result (alu_result),
    .sum_data   (acc_sum),
    .flush_data (acc_flush)
  );

  // Next-state, handshakes and ALU drive; kernel load wins over block accept.
  always_comb begin
    state_d     = state_q;
    kernel_d    = kernel_q;
    blk_d       = blk_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    acc_load    = 1'b0;
    acc_clear   = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_ctrl    = ALU_OP_NOP;
    cfg_ready   = (state_q == IDLE);
    in_ready    = cfg_ready & ~cfg_we;
    case (state_q)
      IDLE: begin
        if (cfg_we) begin
          kernel_d = cfg_kernel;
        end
        if (in_valid && in_ready) begin
          blk_d   = in_data;
          last_d  = in_last;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        alu_a[BLK_W-1:0] = blk_q;
        alu_b[BLK_W-1:0] = kernel_q;
        alu_ctrl         = ALU_OP_CONV;
        acc_load         = 1'b1;
        out_data_d       = acc_sum;
        out_valid_d      = 1'b1;
        out_last_d       = 1'b0;
        state_d          = EMIT;
      end
      EMIT: begin
        if (out_ready) begin
          if (last_q) begin
            out_data_d  = acc_flush;
            out_valid_d = 1'b1;
            out_last_d  = 1'b1;
            state_d     = FLUSH;
          end else begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      FLUSH: begin
        if (out_ready) begin
          acc_clear   = 1'b1;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any block in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      kernel_q    <= '0;
      blk_q       <= '0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      kernel_q    <= kernel_d;
      blk_q       <= blk_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: directed scenarios plus randomized signals checked
// against an overlap-add reference model over absolute sample positions.
module tb_conv_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  int          tests = 0;
  int          fails = 0;

  // OUT_W=8 instance
  logic        cfg_we, cfg_ready, in_valid, in_ready, in_last;
  logic [19:0] cfg_kernel, in_data;
  logic [31:0] alu_a, alu_b, alu_result, out_data;
  logic [2:0]  alu_ctrl;
  logic        out_valid, out_ready, out_last, busy;

  // OUT_W=5 instance
  logic        s_cfg_we, s_cfg_ready, s_in_valid, s_in_ready, s_in_last;
  logic [19:0] s_cfg_kernel, s_in_data;
  logic [31:0] s_alu_a, s_alu_b, s_alu_result;
  logic [19:0] s_out_data;
  logic [2:0]  s_alu_ctrl;
  logic        s_out_valid, s_out_ready, s_out_last, s_busy;

  always #5 clk = ~clk;

  // Partial convolution sample k of one block as the ALU delivers it.
  function automatic int unsigned partial(input logic [19:0] x,
                                          input logic [19:0] h, input int k);
    int unsigned s = 0;
    for (int i = 0; i < 4; i++) begin
      if (k - i >= 0 && k - i < 4) s += x[5*i +: 5] * h[5*(k-i) +: 5];
    end
    return (k == 6) ? (s % 4) : (s % 32);
  endfunction

  function automatic logic [31:0] alu_model(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [2:0] c);
    logic [31:0] r;
    r = '0;
    if (c == 3'b111) begin
      for (int k = 0; k < 6; k++) r[5*k +: 5] = 5'(partial(a[19:0], b[19:0], k));
      r[31:30] = 2'(partial(a[19:0], b[19:0], 6));
    end
    return r;
  endfunction

  assign alu_result   = alu_model(alu_a, alu_b, alu_ctrl);
  assign s_alu_result = alu_model(s_alu_a, s_alu_b, s_alu_ctrl);

  conv_seq_ctrl #(.OUT_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_kernel(cfg_kernel),
    .cfg_ready(cfg_ready), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .alu_result(alu_result), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy));

  conv_seq_ctrl #(.OUT_W(5)) dut5 (
    .clk(clk), .rst(rst), .cfg_we(s_cfg_we), .cfg_kernel(s_cfg_kernel),
    .cfg_ready(s_cfg_ready), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .in_last(s_in_last), .alu_a(s_alu_a), .alu_b(s_alu_b),
    .alu_ctrl(s_alu_ctrl), .alu_result(s_alu_result), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_data(s_out_data), .out_last(s_out_last), .busy(s_busy));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_kernel(input logic [19:0] k);
    cfg_we = 1'b1; cfg_kernel = k;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Returns at the negedge after the accepting edge (DUT then in ISSUE).
  task automatic send_block(input logic [19:0] blk, input logic last);
    int n = 0;
    in_valid = 1'b1; in_data = blk; in_last = last;
    #1;
    while (!in_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("send_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic recv_block(input string tag, input logic [31:0] exp_data,
                            input logic exp_last, input int stall);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk); n++;
    end
    check({tag, "_valid"}, out_valid, 1);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, "_hold"}, out_data, exp_data);
    end
    out_ready = 1'b1;
    check({tag, "_data"}, out_data, exp_data);
    check({tag, "_last"}, out_last, exp_last);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // Random signal checked against overlap-add over absolute sample positions.
  task automatic run_signal(input int nblk);
    logic [19:0] k;
    logic [19:0] blk [8];
    int unsigned acc [40];
    logic [31:0] exp_w;
    k = 20'($urandom);
    load_kernel(k);
    for (int i = 0; i < 40; i++) acc[i] = 0;
    for (int b = 0; b < nblk; b++) begin
      blk[b] = 20'($urandom);
      for (int j = 0; j < 7; j++)
        acc[4*b+j] = (acc[4*b+j] + partial(blk[b], k, j)) % 256;
    end
    for (int b = 0; b < nblk; b++) begin
      send_block(blk[b], b == nblk - 1);
      exp_w = {acc[4*b+3][7:0], acc[4*b+2][7:0], acc[4*b+1][7:0], acc[4*b][7:0]};
      recv_block("rand_blk", exp_w, 1'b0, $urandom_range(0, 3));
    end
    exp_w = {8'h00, acc[4*nblk+2][7:0], acc[4*nblk+1][7:0], acc[4*nblk][7:0]};
    recv_block("rand_flush", exp_w, 1'b1, $urandom_range(0, 2));
  endtask

  initial begin
    logic [4:0] exp_s0;
    rst = 1'b1;
    cfg_we = 0; cfg_kernel = 0; in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;
    s_cfg_we = 0; s_cfg_kernel = 0; s_in_valid = 0; s_in_data = 0; s_in_last = 0;
    s_out_ready = 0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_ctrl", alu_ctrl, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Identity kernel with latency and ALU drive checks
    load_kernel(20'h00001);
    send_block(20'h20C41, 1'b1);
    check("id_alu_ctrl", alu_ctrl, 3'b111);
    check("id_alu_a", alu_a, 32'h00020C41);
    check("id_alu_b", alu_b, 32'h00000001);
    check("id_busy", busy, 1);
    check("id_in_ready", in_ready, 0);
    check("id_lat_not_yet", out_valid, 0);
    @(negedge clk);
    check("id_lat2", out_valid, 1);
    recv_block("id_blk", 32'h04030201, 1'b0, 0);
    check("id_emit_alu_ctrl", alu_ctrl, 3'b000);
    recv_block("id_flush", 32'h00000000, 1'b1, 0);
    check("id_idle_busy", busy, 0);

    // Two blocks with overlap
    load_kernel(20'h00021);
    send_block(20'h08421, 1'b0);
    recv_block("ov_blk0", 32'h02020201, 1'b0, 0);
    send_block(20'h08421, 1'b1);
    recv_block("ov_blk1", 32'h02020202, 1'b0, 1);
    recv_block("ov_flush", 32'h00000001, 1'b1, 0);

    // Backpressure during EMIT
    send_block(20'h08421, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 32'h02020201);
      check("bp_in_ready", in_ready, 0);
      check("bp_alu_ctrl", alu_ctrl, 3'b000);
      @(negedge clk);
    end
    recv_block("bp_blk", 32'h02020201, 1'b0, 0);
    recv_block("bp_flush", 32'h00000001, 1'b1, 0);

    // Config collision: kernel load wins, block accepted next cycle
    cfg_we = 1'b1; cfg_kernel = 20'h00002;
    in_valid = 1'b1; in_data = 20'h20C41; in_last = 1'b1;
    #1 check("coll_in_ready", in_ready, 0);
    @(negedge clk);
    cfg_we = 1'b0;
    #1 check("coll_in_ready_next", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    check("coll_alu_b", alu_b, 32'h00000002);
    recv_block("coll_blk", 32'h08060402, 1'b0, 0);
    recv_block("coll_flush", 32'h00000000, 1'b1, 0);

    // Reset mid-EMIT
    send_block(20'h20C41, 1'b1);
    @(negedge clk);
    check("mid_pre_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_block(20'h20C41, 1'b1);
    check("mid_kernel_lost", alu_b, 32'h00000000);
    recv_block("mid_blk", 32'h00000000, 1'b0, 0);
    recv_block("mid_flush", 32'h00000000, 1'b1, 0);

    // Randomized signals
    for (int s = 0; s < 8; s++) run_signal($urandom_range(1, 5));

    // Saturation boundary on the OUT_W=5 instance
`ifdef CONV_SEQ_CTRL_SAT_EN
    exp_s0 = 5'h1F;
`else
    exp_s0 = 5'h1E;
`endif
    check("sat_cfg_ready", s_cfg_ready, 1);
    s_cfg_we = 1'b1; s_cfg_kernel = 20'h08001;
    @(negedge clk);
    s_cfg_we = 1'b0;
    s_in_valid = 1'b1; s_in_data = 20'h003E0; s_in_last = 1'b0;
    @(negedge clk);
    s_in_valid = 1'b0;
    check("sat_busy", s_busy, 1);
    @(negedge clk);
    check("sat_blk0_valid", s_out_valid, 1);
    check("sat_blk0_data", s_out_data, 20'h003E0);
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;
    s_in_valid = 1'b1; s_in_data = 20'h0001F; s_in_last = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0; s_in_last = 1'b0;
    @(negedge clk);
    check("sat_blk1_valid", s_out_valid, 1);
    check("sat_blk1_s0", s_out_data[4:0], exp_s0);
    check("sat_blk1_s3", s_out_data[19:15], 5'h1F);
    s_out_ready = 1'b1;
    @(negedge clk);
    check("sat_flush_last", s_out_last, 1);
    check("sat_flush_data", s_out_data, 20'h00000);
    @(negedge clk);
    s_out_ready = 1'b0;
    check("sat_done_valid", s_out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
